// File: rtl/sfq_xort_capture.sv
// sfq_xort_capture
//   Capture stage for a clocked SFQ XOR cell. Both the cell clock line and the
//   cell output line are toggle-encoded (every edge is one SFQ pulse). For each
//   SFQ clock period the block decides whether an output pulse belongs to it,
//   packs these bits LSB-first into WIDTH-bit words and queues the words in a
//   DEPTH-entry FIFO read through a valid/ready handshake.
//
//   Handshake: word is the FIFO head and is meaningful only while word_valid is
//   high; a word is consumed on a rising clk edge where word_valid && word_ready.
//   word_valid does not depend combinationally on word_ready.
//
//   Optional feature macro: SFQCAP_TIMING_CHECK_EN. When defined, err becomes
//   sticky on an orphan output pulse (no clock pulse) or on a second output
//   pulse inside one window. When undefined, err is tied low.
//
// Ports
//   clk, rst        oversampling clock, synchronous active-high reset
//   sfq_clk, sfq_q  toggle-encoded SFQ clock and cell output lines (async)
//   word            FIFO head word (0 while empty)
//   word_valid      FIFO non-empty
//   word_ready      consumer accepts word this cycle
//   overflow        sticky: a completed word was dropped on a full FIFO
//   err             sticky timing fault (see macro above)
module sfq_xort_capture #(
  parameter int WIDTH = 8,
  parameter int WIN   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk,
  input  logic             sfq_q,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_WINDOW} state_t;

  // input stage
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_h_q, clk_h_d;
  logic q_s1_q, q_s1_d, q_s2_q, q_s2_d, q_h_q, q_h_d;
  logic [1:0] mask_q, mask_d;
  logic ev_en, clk_ev, q_ev;

  // window FSM and packer
  state_t         state_q, state_d;
  logic [WW-1:0]  win_cnt_q, win_cnt_d;
  logic           cur_bit_q, cur_bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]  bit_idx_q, bit_idx_d;
  logic           commit, commit_bit, push;
  logic [WIDTH-1:0] push_data;

  // FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic           full, pop, push_ok;

  always_comb begin
    clk_s1_d = sfq_clk;
    clk_s2_d = clk_s1_q;
    clk_h_d  = clk_s2_q;
    q_s1_d   = sfq_q;
    q_s2_d   = q_s1_q;
    q_h_d    = q_s2_q;
    // The first cycles after reset see the synchronizers fill from their
    // cleared value, which would look like an edge; hide those.
    mask_d   = (mask_q == 2'd3) ? mask_q : mask_q + 2'd1;
    ev_en    = (mask_q == 2'd3);
    clk_ev   = ev_en & (clk_s2_q ^ clk_h_q);
    q_ev     = ev_en & (q_s2_q ^ q_h_q);
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    cur_bit_d  = cur_bit_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    commit     = 1'b0;
    commit_bit = 1'b0;
    push       = 1'b0;
    push_data  = '0;

    case (state_q)
      S_IDLE: begin
        // A lone q event here is an orphan and is dropped.
        if (clk_ev) begin
          state_d   = S_WINDOW;
          win_cnt_d = '0;
          cur_bit_d = q_ev;
        end
      end
      S_WINDOW: begin
        if (clk_ev || (win_cnt_q == WW'(WIN - 1))) begin
          // A q event coinciding with the close (even one caused by the next
          // clock) belongs to the closing window: the cell output lags its clock.
          commit     = 1'b1;
          commit_bit = cur_bit_q | q_ev;
          win_cnt_d  = '0;
          cur_bit_d  = 1'b0;
          if (!clk_ev) state_d = S_IDLE;
        end else begin
          win_cnt_d = win_cnt_q + WW'(1);
          cur_bit_d = cur_bit_q | q_ev;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      shreg_d[bit_idx_q] = commit_bit;
      if (bit_idx_q == BW'(WIDTH - 1)) begin
        push      = 1'b1;
        push_data = shreg_d;
        bit_idx_d = '0;
      end else begin
        bit_idx_d = bit_idx_q + BW'(1);
      end
    end
  end

  always_comb begin
    full       = (cnt_q == (AW+1)'(DEPTH));
    pop        = word_valid & word_ready;
    // When full, a same-cycle pop frees the slot being written.
    push_ok    = push & (~full | pop);
    overflow_d = overflow_q | (push & full & ~pop);
    mem_d      = mem_q;
    if (push_ok) mem_d[wr_q] = push_data;
    wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_h_q    <= 1'b0;
      q_s1_q     <= 1'b0;
      q_s2_q     <= 1'b0;
      q_h_q      <= 1'b0;
      mask_q     <= 2'd0;
      state_q    <= S_IDLE;
      win_cnt_q  <= '0;
      cur_bit_q  <= 1'b0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_h_q    <= clk_h_d;
      q_s1_q     <= q_s1_d;
      q_s2_q     <= q_s2_d;
      q_h_q      <= q_h_d;
      mask_q     <= mask_d;
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      cur_bit_q  <= cur_bit_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign word_valid = (cnt_q != '0);
  assign word       = word_valid ? mem_q[rd_q] : '0;
  assign overflow   = overflow_q;

`ifdef SFQCAP_TIMING_CHECK_EN
  logic err_q, err_d, orphan, dbl;

  always_comb begin
    orphan = (state_q == S_IDLE) & q_ev & ~clk_ev;
    dbl    = (state_q == S_WINDOW) & q_ev & cur_bit_q;
    err_d  = err_q | orphan | dbl;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
